dbus_access: RTL and testbench
==============================

Name: dbus_access

Overview:
- Memory-stage data-bus controller, directly upstream of the load-data extract/sign-extend logic.
- Takes one load/store per instruction from the EX/MEM pipeline register and drives a valid/addr_ok/data_ok data-bus transaction.
- Aligns store data and byte strobes, and stalls the pipeline until the transaction completes.
- Delivers the raw 64-bit bus word plus addr[2:0], msize and unsigned flag so the downstream extractor can produce the load result.

Parameters:
- ADDR_W, 64, byte-address width.
- DATA_W, 64, bus data width; fixed at 64, with 8 byte strobes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present in MEM stage.
- in_is_load  in  1  instruction is a load.
- in_is_store  in  1  instruction is a store; never both with in_is_load.
- in_addr  in  ADDR_W  effective byte address.
- in_wdata  in  64  store data, right-aligned.
- in_msize  in  msize_t  MSIZE1/2/4/8.
- in_unsigned  in  1  LBU/LHU/LWU.
- stall  out  1  holds all upstream stages.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  ADDR_W  equals in_addr (unmodified byte address).
- dreq_size  out  msize_t  equals in_msize.
- dreq_strobe  out  8  byte write enables; 0 for loads.
- dreq_data  out  64  shifted store data.
- dresp_addr_ok  in  1  request accepted.
- dresp_data_ok  in  1  transaction complete; data valid for loads.
- dresp_data  in  64  raw read word.
- out_valid  out  1  one-cycle pulse: access finished.
- out_raw  out  64  registered dresp_data; 0 for stores or misaligned accesses.
- out_addr_lo  out  3  in_addr[2:0].
- out_msize  out  msize_t  passthrough.
- out_unsigned  out  1  passthrough.
- out_misaligned  out  1  access faulted on alignment.

Behaviour:
- Reset values:
  - state=IDLE; raw register=0.
  - dreq_valid=0, out_valid=0, out_misaligned=0, stall=0, out_raw=0.
- States: IDLE, REQ, WAIT, DONE.
- Memory op: mem = in_valid & (in_is_load | in_is_store).
- Misaligned when any of:
  - MSIZE2 and addr[0].
  - MSIZE4 and addr[1:0]≠0.
  - MSIZE8 and addr[2:0]≠0.
- IDLE:
  - mem & ~misaligned → REQ.
  - mem & misaligned → DONE with the misaligned flag set; no bus request is ever issued.
  - Otherwise stay in IDLE.
- REQ: dreq_valid=1.
  - addr_ok & data_ok in the same cycle → capture data, go to DONE.
  - addr_ok alone → WAIT.
  - Otherwise hold in REQ; all dreq_* outputs stay stable.
- WAIT: dreq_valid=0. data_ok → capture dresp_data, go to DONE.
- DONE: out_valid=1, stall=0, pipeline advances → IDLE.
- DONE is a single cycle even if the next instruction is already a memory op; the next op starts from IDLE one cycle later.
- stall = mem & (state≠DONE). This includes the IDLE cycle in which a memory op arrives. Non-memory ops never stall and pass with zero latency.
- Latency: a load with combined addr_ok/data_ok in its first REQ cycle has out_valid 2 cycles after arrival (IDLE→REQ→DONE).
- Strobe, stores only, o = addr[2:0]:
  - MSIZE1: 8'h01<<o.
  - MSIZE2: 8'h03<<{o[2:1],0}.
  - MSIZE4: 8'h0F<<{o[2],00}.
  - MSIZE8: 8'hFF.
- dreq_data = in_wdata << (8*o), truncated to 64 bits; don't-care for loads but driven deterministically.
- data_ok arriving in IDLE or DONE is ignored.
- Upstream holds all in_* stable while stall=1.
- Reset mid-transaction: return immediately to IDLE and drop dreq_valid. A data_ok arriving afterwards is ignored.
- out_raw is held until the next capture or reset.

Test Plan:
- LD, addr 0x1000, MSIZE8; addr_ok+data_ok in the first REQ cycle with data 0x1122334455667788 → stall for 2 cycles; out_valid in cycle 3 with out_raw=0x1122334455667788, out_addr_lo=0.
- SB, addr 0x2005, wdata 0xAB, MSIZE1 → dreq_strobe=8'h20, dreq_data=0x0000AB0000000000, dreq_valid held for 3 cycles until addr_ok; data_ok 2 cycles later → out_valid, out_raw=0.
- LH, addr 0x3003 → no dreq_valid; out_valid with out_misaligned=1 on the second cycle.
- LW, addr 0x4004; addr_ok in REQ, then data_ok after 4 WAIT cycles with data 0xFFFFFFFF00000000 → out_raw captured, out_addr_lo=4, out_unsigned passed through, stall released only in DONE.
- Assert reset in WAIT, then send data_ok → state IDLE, out_valid stays 0, out_raw=0.
- Back-to-back ADD, SD 0x8: ADD → stall=0 with no bus activity; SD → strobe=8'hFF, completes normally.

Source files
------------

// File: rtl/dbus_access_if.sv
// Data-bus request/response bundle between the memory-stage controller
// (master) and the memory system (slave), plus the shared access-size type.

package dbus_access_pkg;
   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;
endpackage

interface dbus_access_if
   import dbus_access_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              dreq_valid;
   logic [ADDR_W-1:0] dreq_addr;
   msize_t            dreq_size;
   logic [7:0]        dreq_strobe;
   logic [DATA_W-1:0] dreq_data;
   logic              dresp_addr_ok;
   logic              dresp_data_ok;
   logic [DATA_W-1:0] dresp_data;

   modport master (
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_addr_ok, dresp_data_ok, dresp_data
   );

   modport slave (
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_addr_ok, dresp_data_ok, dresp_data
   );
endinterface

// File: rtl/dbus_access.sv
// Memory-stage data-bus controller: issues one valid/addr_ok/data_ok
// transaction per load/store, aligns store data and strobes, stalls the
// pipeline until completion and hands the raw bus word to the extractor.

module dbus_access
   import dbus_access_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_is_load,
   input  logic              in_is_store,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  msize_t            in_msize,
   input  logic              in_unsigned,
   output logic              stall,
   dbus_access_if.master     bus,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_raw,
   output logic [2:0]        out_addr_lo,
   output msize_t            out_msize,
   output logic              out_unsigned,
   output logic              out_misaligned
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_reg;
   logic              dreq_valid_reg;
   logic              out_valid_reg;
   logic              misaligned_reg;
   logic [DATA_W-1:0] raw_reg;

   logic              mem;
   logic              misaligned;
   logic [2:0]        offset;
   logic [7:0]        strobe_next;

   assign mem    = in_valid & (in_is_load | in_is_store);
   assign offset = in_addr[2:0];

   // Natural-alignment check; a faulting access never reaches the bus.
   always_comb begin
      misaligned = 1'b0;
      case (in_msize)
         MSIZE2:  misaligned = offset[0];
         MSIZE4:  misaligned = |offset[1:0];
         MSIZE8:  misaligned = |offset;
         default: misaligned = 1'b0;
      endcase
   end

   // Byte enables for stores, aligned down to the access size; loads write nothing.
   always_comb begin
      strobe_next = 8'h00;
      if (in_is_store) begin
         case (in_msize)
            MSIZE1:  strobe_next = 8'h01 << offset;
            MSIZE2:  strobe_next = 8'h03 << {offset[2:1], 1'b0};
            MSIZE4:  strobe_next = 8'h0F << {offset[2], 2'b00};
            default: strobe_next = 8'hFF;
         endcase
      end
   end

   // Request fields follow the held EX/MEM inputs, so they stay stable while REQ waits.
   assign bus.dreq_valid  = dreq_valid_reg;
   assign bus.dreq_addr   = in_addr;
   assign bus.dreq_size   = in_msize;
   assign bus.dreq_strobe = strobe_next;
   assign bus.dreq_data   = in_wdata << {offset, 3'b000};

   // The pipeline is released only in DONE; non-memory ops pass straight through.
   assign stall          = mem & (state_reg != DONE);
   assign out_valid      = out_valid_reg;
   assign out_raw        = raw_reg;
   assign out_misaligned = misaligned_reg;
   assign out_addr_lo    = offset;
   assign out_msize      = in_msize;
   assign out_unsigned   = in_unsigned;

   // Transaction FSM with registered bus-valid, done pulse, fault flag and read word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         dreq_valid_reg <= 1'b0;
         out_valid_reg  <= 1'b0;
         misaligned_reg <= 1'b0;
         raw_reg        <= '0;
      end else begin
         out_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (mem) begin
                  if (misaligned) begin
                     state_reg      <= DONE;
                     out_valid_reg  <= 1'b1;
                     misaligned_reg <= 1'b1;
                     raw_reg        <= '0;
                  end else begin
                     state_reg      <= REQ;
                     dreq_valid_reg <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (bus.dresp_addr_ok) begin
                  dreq_valid_reg <= 1'b0;
                  if (bus.dresp_data_ok) begin
                     state_reg      <= DONE;
                     out_valid_reg  <= 1'b1;
                     misaligned_reg <= 1'b0;
                     raw_reg        <= in_is_load ? bus.dresp_data : '0;
                  end else begin
                     state_reg <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (bus.dresp_data_ok) begin
                  state_reg      <= DONE;
                  out_valid_reg  <= 1'b1;
                  misaligned_reg <= 1'b0;
                  raw_reg        <= in_is_load ? bus.dresp_data : '0;
               end
            end
            default: begin
               state_reg      <= IDLE;
               misaligned_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dbus_access.sv
// Self-checking bench for dbus_access: directed bus handshakes, a scoreboard
// of expected completions, and a sweep of aligned store strobes/data.

module tb_dbus_access;
   import dbus_access_pkg::*;

   typedef struct {
      logic [63:0] raw;
      logic [2:0]  lo;
      logic        mis;
      logic        uns;
      logic [1:0]  size;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_is_load;
   logic        in_is_store;
   logic [63:0] in_addr;
   logic [63:0] in_wdata;
   msize_t      in_msize;
   logic        in_unsigned;
   logic        stall;
   logic        out_valid;
   logic [63:0] out_raw;
   logic [2:0]  out_addr_lo;
   msize_t      out_msize;
   logic        out_unsigned;
   logic        out_misaligned;

   int checks = 0;
   int errors = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   dbus_access_if #(.ADDR_W(64), .DATA_W(64)) bus ();

   dbus_access #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_is_load     (in_is_load),
      .in_is_store    (in_is_store),
      .in_addr        (in_addr),
      .in_wdata       (in_wdata),
      .in_msize       (in_msize),
      .in_unsigned    (in_unsigned),
      .stall          (stall),
      .bus            (bus.master),
      .out_valid      (out_valid),
      .out_raw        (out_raw),
      .out_addr_lo    (out_addr_lo),
      .out_msize      (out_msize),
      .out_unsigned   (out_unsigned),
      .out_misaligned (out_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic ld, input logic st, input logic [63:0] a,
                        input logic [63:0] w, input msize_t sz, input logic uns);
      in_valid    = 1'b1;
      in_is_load  = ld;
      in_is_store = st;
      in_addr     = a;
      in_wdata    = w;
      in_msize    = sz;
      in_unsigned = uns;
   endtask

   task automatic idle_op();
      in_valid    = 1'b0;
      in_is_load  = 1'b0;
      in_is_store = 1'b0;
   endtask

   task automatic expect_txn(input logic [63:0] raw, input logic [2:0] lo,
                             input logic mis, input logic uns, input msize_t sz);
      exp_t e;
      e.raw  = raw;
      e.lo   = lo;
      e.mis  = mis;
      e.uns  = uns;
      e.size = sz;
      sb_q.push_back(e);
   endtask

   // Completion monitor: every out_valid pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_out_valid", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_out_raw", out_raw, mon_e.raw);
            check("sb_out_addr_lo", {61'd0, out_addr_lo}, {61'd0, mon_e.lo});
            check("sb_out_misaligned", {63'd0, out_misaligned}, {63'd0, mon_e.mis});
            check("sb_out_unsigned", {63'd0, out_unsigned}, {63'd0, mon_e.uns});
            check("sb_out_msize", {62'd0, out_msize}, {62'd0, mon_e.size});
            $display("txn done: raw=%h addr_lo=%0d misaligned=%0b unsigned=%0b msize=%0d",
                     out_raw, out_addr_lo, out_misaligned, out_unsigned, out_msize);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] w;
      logic [63:0] sb_exp;
      logic [15:0] mask;
      reset = 1'b1;
      idle_op();
      in_addr     = '0;
      in_wdata    = '0;
      in_msize    = MSIZE1;
      in_unsigned = 1'b0;
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data    = '0;

      // Reset state
      repeat (2) tick();
      check("rst_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_misaligned", {63'd0, out_misaligned}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_out_raw", out_raw, 64'd0);
      reset = 1'b0;
      tick();

      // LD 0x1000, combined addr_ok/data_ok in first REQ cycle
      drive(1'b1, 1'b0, 64'h1000, 64'd0, MSIZE8, 1'b0);
      expect_txn(64'h1122334455667788, 3'd0, 1'b0, 1'b0, MSIZE8);
      #1;
      check("ld_arrive_stall", {63'd0, stall}, 64'd1);
      check("ld_arrive_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
      tick();
      check("ld_req_dreq_valid", {63'd0, bus.dreq_valid}, 64'd1);
      check("ld_req_stall", {63'd0, stall}, 64'd1);
      check("ld_req_addr", bus.dreq_addr, 64'h1000);
      check("ld_req_strobe", {56'd0, bus.dreq_strobe}, 64'd0);
      bus.dresp_addr_ok = 1'b1;
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = 64'h1122334455667788;
      tick();
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      check("ld_done_out_valid", {63'd0, out_valid}, 64'd1);
      check("ld_done_stall", {63'd0, stall}, 64'd0);
      check("ld_done_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
      idle_op();
      tick();
      check("ld_after_out_valid", {63'd0, out_valid}, 64'd0);
      check("ld_raw_held", out_raw, 64'h1122334455667788);

      // SB 0x2005, addr_ok after 3 REQ cycles, data_ok 2 cycles later
      drive(1'b0, 1'b1, 64'h2005, 64'hAB, MSIZE1, 1'b0);
      expect_txn(64'd0, 3'd5, 1'b0, 1'b0, MSIZE1);
      #1;
      check("sb_strobe", {56'd0, bus.dreq_strobe}, 64'h20);
      check("sb_data", bus.dreq_data, 64'h0000AB0000000000);
      check("sb_arrive_stall", {63'd0, stall}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sb_req_dreq_valid", {63'd0, bus.dreq_valid}, 64'd1);
         check("sb_req_stable_strobe", {56'd0, bus.dreq_strobe}, 64'h20);
      end
      bus.dresp_addr_ok = 1'b1;
      tick();
      bus.dresp_addr_ok = 1'b0;
      check("sb_wait_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
      check("sb_wait_stall", {63'd0, stall}, 64'd1);
      tick();
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = 64'hDEADBEEFDEADBEEF;
      tick();
      bus.dresp_data_ok = 1'b0;
      check("sb_done_out_valid", {63'd0, out_valid}, 64'd1);
      check("sb_done_stall", {63'd0, stall}, 64'd0);
      idle_op();
      tick();

      // LH 0x3003, misaligned: no bus request, completes on the second cycle
      drive(1'b1, 1'b0, 64'h3003, 64'd0, MSIZE2, 1'b0);
      expect_txn(64'd0, 3'd3, 1'b1, 1'b0, MSIZE2);
      #1;
      check("lh_arrive_stall", {63'd0, stall}, 64'd1);
      tick();
      check("lh_done_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
      check("lh_done_out_valid", {63'd0, out_valid}, 64'd1);
      check("lh_done_misaligned", {63'd0, out_misaligned}, 64'd1);
      check("lh_done_stall", {63'd0, stall}, 64'd0);
      idle_op();
      tick();
      check("lh_after_out_valid", {63'd0, out_valid}, 64'd0);
      check("lh_after_misaligned", {63'd0, out_misaligned}, 64'd0);

      // LWU 0x4004: addr_ok in REQ, data_ok in the 4th WAIT cycle
      drive(1'b1, 1'b0, 64'h4004, 64'd0, MSIZE4, 1'b1);
      expect_txn(64'hFFFFFFFF00000000, 3'd4, 1'b0, 1'b1, MSIZE4);
      tick();
      check("lw_req_dreq_valid", {63'd0, bus.dreq_valid}, 64'd1);
      bus.dresp_addr_ok = 1'b1;
      tick();
      bus.dresp_addr_ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("lw_wait_stall", {63'd0, stall}, 64'd1);
         check("lw_wait_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
         check("lw_wait_out_valid", {63'd0, out_valid}, 64'd0);
         if (i == 3) begin
            bus.dresp_data_ok = 1'b1;
            bus.dresp_data    = 64'hFFFFFFFF00000000;
         end
         tick();
      end
      bus.dresp_data_ok = 1'b0;
      check("lw_done_out_valid", {63'd0, out_valid}, 64'd1);
      check("lw_done_stall", {63'd0, stall}, 64'd0);
      idle_op();
      tick();

      // Reset while in WAIT, then a stray data_ok
      drive(1'b1, 1'b0, 64'h5000, 64'd0, MSIZE8, 1'b0);
      tick();
      bus.dresp_addr_ok = 1'b1;
      tick();
      bus.dresp_addr_ok = 1'b0;
      check("rw_wait_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
      check("rw_raw_before", out_raw, 64'hFFFFFFFF00000000);
      reset = 1'b1;
      idle_op();
      #1;
      check("rw_rst_out_raw", out_raw, 64'd0);
      check("rw_rst_stall", {63'd0, stall}, 64'd0);
      tick();
      reset = 1'b0;
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = 64'h0123012301230123;
      tick();
      bus.dresp_data_ok = 1'b0;
      check("rw_after_out_valid", {63'd0, out_valid}, 64'd0);
      check("rw_after_out_raw", out_raw, 64'd0);
      check("rw_after_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
      tick();

      // ADD (non-memory) then SD 0x8
      drive(1'b0, 1'b0, 64'h8, 64'd0, MSIZE8, 1'b0);
      #1;
      check("add_stall", {63'd0, stall}, 64'd0);
      tick();
      check("add_dreq_valid", {63'd0, bus.dreq_valid}, 64'd0);
      check("add_out_valid", {63'd0, out_valid}, 64'd0);
      drive(1'b0, 1'b1, 64'h8, 64'h0123456789ABCDEF, MSIZE8, 1'b0);
      expect_txn(64'd0, 3'd0, 1'b0, 1'b0, MSIZE8);
      #1;
      check("sd_stall", {63'd0, stall}, 64'd1);
      check("sd_strobe", {56'd0, bus.dreq_strobe}, 64'hFF);
      check("sd_data", bus.dreq_data, 64'h0123456789ABCDEF);
      tick();
      check("sd_req_dreq_valid", {63'd0, bus.dreq_valid}, 64'd1);
      bus.dresp_addr_ok = 1'b1;
      bus.dresp_data_ok = 1'b1;
      tick();
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      check("sd_done_out_valid", {63'd0, out_valid}, 64'd1);
      idle_op();
      tick();

      // Sweep of aligned store strobes and shifted data (inputs withdrawn before the edge)
      w = 64'h8877665544332211;
      for (int s = 0; s < 4; s++) begin
         for (int o = 0; o < 8; o += (1 << s)) begin
            drive(1'b0, 1'b1, 64'h100 + 64'(o), w, msize_t'(s), 1'b0);
            #1;
            mask   = ((16'h1 << (1 << s)) - 16'h1) << o;
            sb_exp = w << (8 * o);
            check("sweep_strobe", {56'd0, bus.dreq_strobe}, {56'd0, mask[7:0]});
            check("sweep_data", bus.dreq_data, sb_exp);
            idle_op();
            tick();
         end
      end

      tick();
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
